// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair: mult/multu, div/divu, mthi/mtlo.
// Define MDU_DIV_EN to build the divider and the div/divu ops; otherwise only the multiplier exists.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);
    // Handshake: start is a request taken only on an edge where busy is low (no queueing,
    // no backpressure); done pulses for one cycle in the first cycle HI/LO hold the new result.

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 signed_op, a_neg, b_neg, accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step, prod;

`ifdef MDU_DIV_EN
    logic                 div_q, div_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     araw_q, araw_d;
    logic [WIDTH:0]       rem_sh, rem_diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [WIDTH-1:0]     quo, rem;
`endif

    always_comb begin : operand_prep
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
`ifdef MDU_DIV_EN
        accept    = start;
`else
        accept    = start & ~op[1];
`endif
    end

    // acc_q holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin : datapath
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
`ifdef MDU_DIV_EN
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        if (!rem_diff[WIDTH]) begin
            div_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        quo = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
`endif
    end

    always_comb begin : fsm
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MDU_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        araw_d  = araw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    m_d     = a_mag;
`ifdef MDU_DIV_EN
                    div_d   = op[1];
                    rneg_d  = a_neg;
                    dz_d    = (b == '0);
                    araw_d  = a;
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        m_d   = b_mag;
                    end
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = mul_step;
`ifdef MDU_DIV_EN
                if (div_q) acc_d = div_step;
`endif
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
                // Divide by zero returns the raw dividend in HI rather than a sign-fixed remainder.
                if (div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = araw_q;
                    end else begin
                        lo_d = quo;
                        hi_d = rem;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            araw_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            araw_q  <= araw_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mdu_hilo;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [1:0]   state_dbg;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    // Behavioural model: remaining edges of the current op, architectural HI/LO, expected results.
    int           m_cnt  = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic         m_done = 1'b0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic op_ok(input logic [1:0] o);
`ifdef MDU_DIV_EN
        return 1'b1;
`else
        return !o[1];
`endif
    endfunction

    // Returns {HI, LO} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] p;
        int          qi, ri;
        case (o)
            2'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
            end
            2'd1: p = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == 2'd3) begin
                    p = {x % y, x / y};
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    p = {32'd0, 32'h8000_0000};
                end else begin
                    qi = $signed(x) / $signed(y);
                    ri = $signed(x) % $signed(y);
                    p  = {ri, qi};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = exp_q.pop_front();
                    m_done = 1'b1;
                end
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
                if (start && op_ok(op)) begin
                    exp_q.push_back(ref_result(op, a, b));
                    m_cnt = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_cnt > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Caller is at a negedge; returns edges from the start edge to the done cycle.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int edges, output int busy_cycles);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, busy_cycles);
    endtask

    task automatic count_events(input int cycles, output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
    endtask

    initial begin
        int ed, bc, nd, nb;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;

        check("model_mult_neg", ref_result(2'd0, 32'hFFFF_FFFD, 32'd4), 64'hFFFF_FFFF_FFFF_FFF4);
        check("model_multu_max", ref_result(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("model_div_neg", ref_result(2'd2, 32'd7, 32'hFFFF_FFFE), 64'h0000_0001_FFFF_FFFD);
        check("model_divu_zero", ref_result(2'd3, 32'd7, 32'd0), 64'h0000_0007_FFFF_FFFF);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        run_op(2'd0, 32'd3, 32'd4, ed, bc);
        check("mult_latency", 64'(ed), 64'd33);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        check("mult_3x4_hi", 64'(hi), 64'h0);
        check("mult_3x4_lo", 64'(lo), 64'hC);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd4, ed, bc);
        check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFF_FFF4);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ed, bc);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);

        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        check("mthi_lo_kept", 64'(lo), 64'h0000_0001);

        start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        mtlo = 1'b1; wdata = 32'h1234_5678; start = 1'b1; a = 32'd7; b = 32'd7;
        @(negedge clk);
        mtlo = 1'b0; start = 1'b0;
        wait_done(ed, bc);
        check("run_mtlo_ignored_lo", 64'(lo), 64'd30);
        check("run_mtlo_ignored_hi", 64'(hi), 64'd0);
        count_events(40, nd, nb);
        check("no_second_done", 64'(nd), 64'd0);

        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        count_events(40, nd, nb);
        check("abort_no_done", 64'(nd), 64'd0);
        run_op(2'd0, 32'd3, 32'd4, ed, bc);
        check("after_abort_latency", 64'(ed), 64'd33);
        check("after_abort_lo", 64'(lo), 64'hC);

`ifdef MDU_DIV_EN
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, ed, bc);
        check("div_latency", 64'(ed), 64'd33);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'h0000_0001);
        run_op(2'd3, 32'd7, 32'd0, ed, bc);
        check("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
        check("divu_zero_hi", 64'(hi), 64'h0000_0007);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, ed, bc);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'h0);
`else
        start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        count_events(40, nd, nb);
        check("nodiv_busy", 64'(nb), 64'd0);
        check("nodiv_done", 64'(nd), 64'd0);
        check("nodiv_hi", 64'(hi), 64'h0);
        check("nodiv_lo", 64'(lo), 64'hC);
`endif

        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 9) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            mthi  = ($urandom_range(0, 15) == 0);
            mtlo  = ($urandom_range(0, 15) == 0);
            wdata = $urandom;
            rst   = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
